// File: rtl/enc64_seq.sv
// Sequencer that pushes one 64-bit word through a shared 32->39 SECDED encoder in two passes
// (low half, then high half) and presents the combined 78-bit codeword over valid/ready.
module enc64_seq #(
   parameter int unsigned HALF_W = 32,
   parameter int unsigned CODE_W = 39,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2*HALF_W-1:0] in_data,
   output logic [HALF_W-1:0]   enc_in,
   input  logic [CODE_W-1:0]   enc_out,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2*CODE_W-1:0] out_code,
   output logic                busy,
   output logic [CNT_W-1:0]    words_done
);

   typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

   state_e              state_q, state_d;
   logic [2*HALF_W-1:0] data_q, data_d;
   logic [CODE_W-1:0]   code_lo_q, code_lo_d;
   logic [CODE_W-1:0]   code_hi_q, code_hi_d;
   logic [CNT_W-1:0]    words_q, words_d;

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      code_lo_d = code_lo_q;
      code_hi_d = code_hi_q;
      words_d   = words_q;
      in_ready  = 1'b0;
      enc_in    = '0;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               data_d  = in_data;
               state_d = StLo;
            end
         end
         StLo: begin
            enc_in    = data_q[HALF_W-1:0];
            code_lo_d = enc_out;
            state_d   = StHi;
         end
         StHi: begin
            enc_in    = data_q[2*HALF_W-1:HALF_W];
            code_hi_d = enc_out;
            state_d   = StDone;
         end
         StDone: begin
            // Accepting a new word here lets a retiring codeword chain straight into LO.
            in_ready = out_ready;
            if (out_ready) begin
               words_d = words_q + 1'b1;
               if (in_valid) begin
                  data_d  = in_data;
                  state_d = StLo;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         data_q    <= '0;
         code_lo_q <= '0;
         code_hi_q <= '0;
         words_q   <= '0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         code_lo_q <= code_lo_d;
         code_hi_q <= code_hi_d;
         words_q   <= words_d;
      end
   end

   assign out_valid  = (state_q == StDone);
   assign busy       = (state_q != StIdle);
   assign out_code   = {code_hi_q, code_lo_q};
   assign words_done = words_q;

endmodule
